ula_display: RTL and testbench
==============================

# ula_display

Sequential result decoder for the 4-bit ALU (`ula`). It captures an ALU result (`saida`) and the operation code (`switchs`) that produced it, and converts the result to sign plus three BCD digits by iterative double-dabble. It then drives four seven-segment digit codes for the board display. It sits downstream of `ula`, on the consumer side of its `saida` bus.

## Interface
- `HEX_ATIVO_BAIXO`, default 1: 1 means segment outputs are active-low, 0 means active-high.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `valido`, in, 1: request to convert; sampled only while `pronto`=1.
- `pronto`, out, 1: block is idle and can accept a request.
- `switchs`, in, 4: operation code that produced `saida`. 0001 is a signed subtraction result; every other code is unsigned.
- `saida`, in, 8: ALU result to display.
- `feito`, out, 1: one-cycle pulse when outputs update.
- `sinal`, out, 1: 1 when the displayed value is negative.
- `bcd`, out, 12: {hundreds, tens, units}, 4 bits each.
- `hex3`, out, 7: sign digit, segments {g,f,e,d,c,b,a}.
- `hex2`, `hex1`, `hex0`, out, 7 each: hundreds, tens and units digits.

## Operation
- States:
  - IDLE: `pronto`=1.
  - CONV: 8 iterations, `pronto`=0.
  - After the last iteration the block returns to IDLE.
- Accept: on a rising edge with IDLE and `valido`=1:
  - Capture `switchs` and `saida`.
  - Compute the magnitude. If `switchs`=0001 and `saida[7]`=1, `mag` = (~saida)+1, with 8'h80 giving 128. Otherwise `mag` = `saida`.
  - Capture the sign flag.
  - Clear the 12-bit BCD scratch and the iteration counter, then go to CONV.
- CONV iteration, one per edge:
  - Add 3 to each BCD nibble that is ≥5.
  - Then shift {bcd, mag} left by 1.
  - The counter runs 0..7.
  - On the edge with counter=7:
    - Register `bcd`, `sinal` and `hex0`-`hex3`.
    - Assert `feito` for exactly one cycle.
    - Return to IDLE.
- Range: unsigned 0..255, signed -128..127. Every value fits in 3 BCD digits, so there is no overflow case.
- Digit encoding, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Minus = 40, blank = 00.
  - When `HEX_ATIVO_BAIXO`=1, all codes are inverted.
- Leading-zero blanking:
  - `hex2` is blank if hundreds=0.
  - `hex1` is blank if hundreds=0 and tens=0.
  - `hex0` is always shown.
  - `hex3` shows minus if `sinal`=1, otherwise blank.
  - Negative zero cannot occur; 8'h00 under 0001 gives `sinal`=0.
- `valido` during CONV is ignored; there is no queueing.
- `switchs` and `saida` changes after accept do not affect the conversion in progress.

## Timing
- Reset values:
  - IDLE, `pronto`=1, `feito`=0, `sinal`=0, `bcd`=0.
  - `hex0`-`hex3` = blank (7'h7F active-low, 7'h00 active-high).
  - Counter and scratch = 0.
- `pronto` is registered. It falls on the accept edge and rises on the edge that asserts `feito`.
- Latency: `feito` rises on the 8th rising edge after the accept edge. The earliest next accept is the edge after `feito` is seen high, giving a throughput of one conversion per 9 cycles.
- Outputs hold their last value between conversions.
- Reset asserted mid-CONV:
  - Immediate return to reset values.
  - No `feito` pulse.
  - `pronto`=1 while `rst_n` is low and after release.

## Structure
- A shared package `ula_pkg` holds:
  - Opcode constants OP_SOMA=0000, OP_SUB=0001, OP_MUL=0010, OP_DIV=0011. `ula` is to adopt these too.
  - The state enum.
  - The seven-segment code constants, including SEG_MENOS and SEG_APAGADO.
- One sub-module, `bcd_7seg`: combinational nibble-to-segment encoder with a blank input, instantiated three times. The sign digit is driven directly from the package constants.

## Test plan
1. Reset checks:
   - Assert `rst_n`=0 → `pronto`=1, `feito`=0, `bcd`=000, all hex=7F.
   - Release reset with `valido`=0 for 20 cycles → no change.
2. Unsigned addition result, `switchs`=0000, `saida`=8'h1E, `valido` for one cycle:
   - `feito` on the 8th edge after accept.
   - `bcd`=12'h030, `sinal`=0.
   - hex3=7F, hex2=7F, hex1=30, hex0=40.
3. Signed subtraction result, `switchs`=0001, `saida`=8'hFD:
   - `sinal`=1, `bcd`=003.
   - hex3=3F, hex2=7F, hex1=7F, hex0=30.
   - Repeat with 8'h80 → `bcd`=128, `sinal`=1.
4. Multiplication result, `switchs`=0010, `saida`=8'hE1:
   - `bcd`=225, `sinal`=0.
   - hex2=24, hex1=24, hex0=12.
   - Then `switchs`=0011, `saida`=8'h00 → `bcd`=000, hex0=40, others 7F.
5. Busy handling:
   - Hold `valido`=1 and change `saida` every cycle during CONV → only the first captured value is displayed.
   - `pronto`=0 for exactly 8 cycles.
   - Back-to-back accept on the cycle after `feito`.
6. Reset mid-conversion: drop `rst_n` at iteration 4 → no `feito`, outputs return to reset values, and the next request converts correctly.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the 4-bit ALU and its display decoder.
// Opcodes, decoder states and seven-segment codes (active-high {g..a}).
package ula_pkg;

    localparam logic [3:0] OP_SOMA = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } estado_t;

    localparam int unsigned N_ITER = 8;

    localparam logic [6:0] SEG_0       = 7'h3F;
    localparam logic [6:0] SEG_1       = 7'h06;
    localparam logic [6:0] SEG_2       = 7'h5B;
    localparam logic [6:0] SEG_3       = 7'h4F;
    localparam logic [6:0] SEG_4       = 7'h66;
    localparam logic [6:0] SEG_5       = 7'h6D;
    localparam logic [6:0] SEG_6       = 7'h7D;
    localparam logic [6:0] SEG_7       = 7'h07;
    localparam logic [6:0] SEG_8       = 7'h7F;
    localparam logic [6:0] SEG_9       = 7'h6F;
    localparam logic [6:0] SEG_MENOS   = 7'h40;
    localparam logic [6:0] SEG_APAGADO = 7'h00;

    // Active-high segment pattern for one BCD digit; non-decimal codes go dark.
    function automatic logic [6:0] seg_digito(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_APAGADO;
        case (d)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = SEG_APAGADO;
        endcase
        return s;
    endfunction

    // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
    function automatic logic [3:0] ajusta(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/ula_display_bcd_7seg.sv
// Nibble to seven-segment encoder with blanking input.
// Polarity is chosen per instance.
import ula_pkg::*;

module bcd_7seg #(
    parameter bit ATIVO_BAIXO = 1'b1
) (
    input  logic [3:0] digito,
    input  logic       apagar,
    output logic [6:0] seg
);

    logic [6:0] ativo;

    // Select the digit pattern or blank, then apply output polarity.
    always_comb begin
        ativo = apagar ? SEG_APAGADO : seg_digito(digito);
        seg   = ATIVO_BAIXO ? ~ativo : ativo;
    end

endmodule

// File: rtl/ula_display.sv
// ALU result decoder: captures saida/switchs, converts to sign + 3 BCD
// digits by 8 double-dabble iterations and drives four 7-segment digits.
import ula_pkg::*;

module ula_display #(
    parameter bit HEX_ATIVO_BAIXO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valido,
    output logic        pronto,
    input  logic [3:0]  switchs,
    input  logic [7:0]  saida,
    output logic        feito,
    output logic        sinal,
    output logic [11:0] bcd,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0
);

    localparam logic [6:0] HEX_APAGADO =
        HEX_ATIVO_BAIXO ? ~SEG_APAGADO : SEG_APAGADO;
    localparam logic [6:0] HEX_MENOS =
        HEX_ATIVO_BAIXO ? ~SEG_MENOS : SEG_MENOS;

    estado_t     estado;
    estado_t     prox;
    logic        aceita;
    logic        ultimo;

    logic [2:0]  cnt;
    logic [7:0]  mag;
    logic [11:0] rasc;
    logic        neg;

    logic        neg_in;
    logic [7:0]  mag_in;
    logic [11:0] rasc_aj;
    logic [11:0] rasc_prox;
    logic [7:0]  mag_prox;

    logic        apaga2;
    logic        apaga1;
    logic [6:0]  seg2;
    logic [6:0]  seg1;
    logic [6:0]  seg0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= prox;
        end
    end

    // Next state: accept in IDLE, leave CONV after the eighth iteration.
    always_comb begin
        prox   = estado;
        aceita = 1'b0;
        ultimo = 1'b0;
        unique case (estado)
            IDLE: begin
                if (valido) begin
                    prox   = CONV;
                    aceita = 1'b1;
                end
            end
            CONV: begin
                if (cnt == 3'(N_ITER - 1)) begin
                    prox   = IDLE;
                    ultimo = 1'b1;
                end
            end
        endcase
    end

    // Magnitude and sign of the incoming result; 8'h80 maps to 128.
    always_comb begin
        neg_in = (switchs == OP_SUB) && saida[7];
        mag_in = neg_in ? (~saida + 8'd1) : saida;
    end

    // One double-dabble step: correct nibbles, then shift {bcd, mag} left.
    always_comb begin
        rasc_aj   = {ajusta(rasc[11:8]), ajusta(rasc[7:4]), ajusta(rasc[3:0])};
        rasc_prox = {rasc_aj[10:0], mag[7]};
        mag_prox  = {mag[6:0], 1'b0};
    end

    // Leading-zero blanking based on the final BCD value.
    always_comb begin
        apaga2 = (rasc_prox[11:8] == 4'd0);
        apaga1 = apaga2 && (rasc_prox[7:4] == 4'd0);
    end

    bcd_7seg #(.ATIVO_BAIXO(HEX_ATIVO_BAIXO)) u_seg2 (
        .digito (rasc_prox[11:8]),
        .apagar (apaga2),
        .seg    (seg2)
    );

    bcd_7seg #(.ATIVO_BAIXO(HEX_ATIVO_BAIXO)) u_seg1 (
        .digito (rasc_prox[7:4]),
        .apagar (apaga1),
        .seg    (seg1)
    );

    bcd_7seg #(.ATIVO_BAIXO(HEX_ATIVO_BAIXO)) u_seg0 (
        .digito (rasc_prox[3:0]),
        .apagar (1'b0),
        .seg    (seg0)
    );

    // Conversion datapath and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pronto <= 1'b1;
            feito  <= 1'b0;
            sinal  <= 1'b0;
            bcd    <= '0;
            hex3   <= HEX_APAGADO;
            hex2   <= HEX_APAGADO;
            hex1   <= HEX_APAGADO;
            hex0   <= HEX_APAGADO;
            cnt    <= '0;
            mag    <= '0;
            rasc   <= '0;
            neg    <= 1'b0;
        end else begin
            pronto <= (prox == IDLE);
            feito  <= 1'b0;
            if (aceita) begin
                mag  <= mag_in;
                neg  <= neg_in;
                rasc <= '0;
                cnt  <= '0;
            end else if (estado == CONV) begin
                rasc <= rasc_prox;
                mag  <= mag_prox;
                cnt  <= cnt + 3'd1;
                if (ultimo) begin
                    bcd   <= rasc_prox;
                    sinal <= neg;
                    hex3  <= neg ? HEX_MENOS : HEX_APAGADO;
                    hex2  <= seg2;
                    hex1  <= seg1;
                    hex0  <= seg0;
                    feito <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_display.sv
// Bench for ula_display: reference vectors, randomized scoreboard runs,
// busy handling and reset during conversion.
module tb_ula_display;

    typedef struct {
        logic [3:0]  sw;
        logic [7:0]  sa;
        logic [11:0] bcd;
        logic        sinal;
        logic [6:0]  h3;
        logic [6:0]  h2;
        logic [6:0]  h1;
        logic [6:0]  h0;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valido;
    logic        pronto;
    logic [3:0]  switchs;
    logic [7:0]  saida;
    logic        feito;
    logic        sinal;
    logic [11:0] bcd;
    logic [6:0]  hex3;
    logic [6:0]  hex2;
    logic [6:0]  hex1;
    logic [6:0]  hex0;

    int   n_chk  = 0;
    int   n_fail = 0;
    rec_t sb[$];
    rec_t tab[11];
    logic [6:0] segtab[10];

    always #5 clk = ~clk;

    ula_display #(.HEX_ATIVO_BAIXO(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valido  (valido),
        .pronto  (pronto),
        .switchs (switchs),
        .saida   (saida),
        .feito   (feito),
        .sinal   (sinal),
        .bcd     (bcd),
        .hex3    (hex3),
        .hex2    (hex2),
        .hex1    (hex1),
        .hex0    (hex0)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Independent reference: arithmetic digits and an active-low lookup table.
    function automatic rec_t model(input logic [3:0] sw, input logic [7:0] sa);
        rec_t r;
        int v, h, t, u;
        r.sw = sw;
        r.sa = sa;
        r.sinal = (sw == 4'd1) && sa[7];
        v = r.sinal ? 256 - int'(sa) : int'(sa);
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        r.bcd = {4'(h), 4'(t), 4'(u)};
        r.h3 = r.sinal ? 7'h3F : 7'h7F;
        r.h2 = (h == 0) ? 7'h7F : segtab[h];
        r.h1 = (h == 0 && t == 0) ? 7'h7F : segtab[t];
        r.h0 = segtab[u];
        return r;
    endfunction

    task automatic check_reset_outs(input string nm);
        chk({nm, "_pronto"}, 32'(pronto), 32'd1);
        chk({nm, "_feito"}, 32'(feito), 32'd0);
        chk({nm, "_sinal"}, 32'(sinal), 32'd0);
        chk({nm, "_bcd"}, 32'(bcd), 32'h000);
        chk({nm, "_hex"}, {4'h0, hex3, hex2, hex1, hex0},
            {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    endtask

    task automatic confere(input string nm);
        rec_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_sb: feito with empty scoreboard", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_bcd"}, 32'(bcd), 32'(e.bcd));
            chk({nm, "_sinal"}, 32'(sinal), 32'(e.sinal));
            chk({nm, "_hex3"}, 32'(hex3), 32'(e.h3));
            chk({nm, "_hex2"}, 32'(hex2), 32'(e.h2));
            chk({nm, "_hex1"}, 32'(hex1), 32'(e.h1));
            chk({nm, "_hex0"}, 32'(hex0), 32'(e.h0));
        end
    endtask

    // Accept one request (DUT idle), optionally keep valido high and
    // scramble inputs during CONV, then wait for feito and compare.
    task automatic run_one(input string nm, input rec_t e, input bit hold);
        int lat, busy;
        valido  = 1'b1;
        switchs = e.sw;
        saida   = e.sa;
        @(posedge clk);
        #1;
        sb.push_back(e);
        if (!hold) valido = 1'b0;
        chk({nm, "_pronto_fall"}, 32'(pronto), 32'd0);
        lat  = 0;
        busy = 0;
        while (!feito && lat < 20) begin
            if (!pronto) busy++;
            if (hold) begin
                saida   = 8'($urandom);
                switchs = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        valido = 1'b0;
        chk({nm, "_lat"}, 32'(lat), 32'd8);
        chk({nm, "_busy"}, 32'(busy), 32'd8);
        chk({nm, "_pronto_rise"}, 32'(pronto), 32'd1);
        if (feito) confere(nm);
    endtask

    initial begin
        segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24;
        segtab[3] = 7'h30; segtab[4] = 7'h19; segtab[5] = 7'h12;
        segtab[6] = 7'h02; segtab[7] = 7'h78; segtab[8] = 7'h00;
        segtab[9] = 7'h10;

        tab[0]  = '{4'h0, 8'h1E, 12'h030, 1'b0, 7'h7F, 7'h7F, 7'h30, 7'h40};
        tab[1]  = '{4'h1, 8'hFD, 12'h003, 1'b1, 7'h3F, 7'h7F, 7'h7F, 7'h30};
        tab[2]  = '{4'h1, 8'h80, 12'h128, 1'b1, 7'h3F, 7'h79, 7'h24, 7'h00};
        tab[3]  = '{4'h2, 8'hE1, 12'h225, 1'b0, 7'h7F, 7'h24, 7'h24, 7'h12};
        tab[4]  = '{4'h3, 8'h00, 12'h000, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        tab[5]  = '{4'h1, 8'h00, 12'h000, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        tab[6]  = '{4'h1, 8'h7F, 12'h127, 1'b0, 7'h7F, 7'h79, 7'h24, 7'h78};
        tab[7]  = '{4'h0, 8'hFF, 12'h255, 1'b0, 7'h7F, 7'h24, 7'h12, 7'h12};
        tab[8]  = '{4'h5, 8'h09, 12'h009, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h10};
        tab[9]  = '{4'h1, 8'hF6, 12'h010, 1'b1, 7'h3F, 7'h7F, 7'h79, 7'h40};
        tab[10] = '{4'h0, 8'h64, 12'h100, 1'b0, 7'h7F, 7'h79, 7'h40, 7'h40};

        rst_n   = 1'b0;
        valido  = 1'b0;
        switchs = 4'h0;
        saida   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_hold", {pronto, feito}, 32'b10);
        end
        check_reset_outs("idle_after");

        for (int i = 0; i < 11; i++)
            run_one($sformatf("vec%0d", i), tab[i], 1'b0);

        for (int i = 0; i < 24; i++)
            run_one($sformatf("rnd%0d", i),
                    model(4'($urandom_range(0, 3)), 8'($urandom)), 1'b0);

        run_one("busy", model(4'h0, 8'h2A), 1'b1);
        run_one("b2b", model(4'h1, 8'h9C), 1'b0);
        chk("feito_pulse", 32'(feito), 32'd1);
        @(posedge clk);
        #1;
        chk("feito_one_cycle", 32'(feito), 32'd0);

        valido  = 1'b1;
        switchs = 4'h2;
        saida   = 8'hC8;
        @(posedge clk);
        #1;
        valido = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) rst_n = 1'b1;
            chk("midrst_no_feito", 32'(feito), 32'd0);
        end
        check_reset_outs("midrst_after");
        run_one("post_rst", model(4'h1, 8'h85), 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
